// File: rtl/fir_pkg.sv
// Shared definitions for the FIR decimator front end: default geometry,
// frame/sample types and the lane-to-bit mapping used for frame packing.
package fir_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int CHANNELS   = 2;
  localparam int PSAMPLES   = 8;
  localparam int FRAME_W    = CHANNELS * DATA_WIDTH * PSAMPLES;

  typedef logic signed [DATA_WIDTH-1:0] sample_t;
  typedef logic [FRAME_W-1:0]           frame_t;

  // Bit offset of channel c, lane i inside a frame; lane 0 is the oldest sample.
  function automatic int lane_offset(input int c, input int i);
    return (c * PSAMPLES + i) * DATA_WIDTH;
  endfunction

endpackage

// File: rtl/fir_frame_fifo.sv
// Two-entry FIFO holding {tlast, frame}. ready_o depends only on the stored
// count, so the upstream ready never sees the downstream ready combinationally.
module fir_frame_fifo #(
  parameter int W = 257
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [1:0]   count_o,
  output logic         valid_o,
  output logic         ready_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] mem_q [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push;
  logic         do_pop;

  assign valid_o = (count_q != 2'd0);
  assign ready_o = (count_q != 2'd2);
  assign count_o = count_q;
  // Empty FIFO presents zero rather than a stale, already-consumed frame.
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  assign do_push = push_i && ready_o;
  assign do_pop  = pop_i && valid_o;

  // Pointer and occupancy next-state.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ~wr_ptr_q;
    if (do_pop)  rd_ptr_d = ~rd_ptr_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers; reset drops every buffered frame.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fir_frame_packer.sv
// Gathers PSAMPLES sample sets per channel into one wide frame for the FIR,
// closing early on s_tlast, and buffers finished frames in a 2-entry FIFO.
module fir_frame_packer
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = fir_pkg::DATA_WIDTH,
  parameter int CHANNELS   = fir_pkg::CHANNELS,
  parameter int PSAMPLES   = fir_pkg::PSAMPLES
) (
  input  logic                                   clk,
  input  logic                                   nrst,
  input  logic                                   s_tvalid,
  output logic                                   s_tready,
  input  logic [CHANNELS*DATA_WIDTH-1:0]         s_tdata,
  input  logic                                   s_tlast,
  output logic                                   m_tvalid,
  input  logic                                   m_tready,
  output logic [CHANNELS*DATA_WIDTH*PSAMPLES-1:0] m_tdata,
  output logic                                   m_tlast,
  output logic [31:0]                            frame_cnt
);

  localparam int FW = CHANNELS * DATA_WIDTH * PSAMPLES;
  localparam int LW = (PSAMPLES > 2) ? $clog2(PSAMPLES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(PSAMPLES - 1);

  logic [LW-1:0]         lane_q, lane_d;
  logic [FW-1:0]         fill_q, fill_d;
  logic [FW-1:0]         frame_d;
  logic [31:0]           frame_cnt_q, frame_cnt_d;
  logic                  live_q;
  logic                  accept;
  logic                  close;
  logic                  fifo_ready;
  logic [1:0]            fifo_count;
  logic [FW:0]           fifo_head;
  logic [DATA_WIDTH-1:0] samples [CHANNELS];

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_split
      assign samples[gi] = s_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Ready is purely registered state: out of reset and a free FIFO entry.
  assign s_tready = live_q && fifo_ready;
  assign accept   = s_tvalid && s_tready;
  assign close    = accept && ((lane_q == LAST_LANE) || s_tlast);

  // Current fill register with this handshake's samples dropped into lane_q.
  always_comb begin
    frame_d = fill_q;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int i = 0; i < PSAMPLES; i++) begin
        if (lane_q == LW'(i)) begin
          frame_d[(c*PSAMPLES+i)*DATA_WIDTH +: DATA_WIDTH] = samples[c];
        end
      end
    end
  end

  // Lane counter, fill register and frame counter next-state.
  always_comb begin
    lane_d      = lane_q;
    fill_d      = fill_q;
    frame_cnt_d = frame_cnt_q;
    if (close) begin
      lane_d      = '0;
      fill_d      = '0;
      frame_cnt_d = frame_cnt_q + 32'd1;
    end else if (accept) begin
      lane_d = lane_q + LW'(1);
      fill_d = frame_d;
    end
  end

  // Packing state; reset discards any partially filled frame.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lane_q      <= '0;
      fill_q      <= '0;
      frame_cnt_q <= 32'd0;
      live_q      <= 1'b0;
    end else begin
      lane_q      <= lane_d;
      fill_q      <= fill_d;
      frame_cnt_q <= frame_cnt_d;
      live_q      <= 1'b1;
    end
  end

  fir_frame_fifo #(
    .W (FW + 1)
  ) u_fifo (
    .clk         (clk),
    .nrst        (nrst),
    .push_i      (close),
    .push_data_i ({s_tlast, frame_d}),
    .pop_i       (m_tready),
    .count_o     (fifo_count),
    .valid_o     (m_tvalid),
    .ready_o     (fifo_ready),
    .head_o      (fifo_head)
  );

  assign m_tdata   = fifo_head[FW-1:0];
  assign m_tlast   = fifo_head[FW];
  assign frame_cnt = frame_cnt_q;

  // Occupancy is only needed inside the FIFO's ready/valid decode.
  logic unused_ok;
  assign unused_ok = ^fifo_count;

endmodule

// File: tb/tb_fir_frame_packer.sv
module tb_fir_frame_packer;
  import fir_pkg::*;

  logic                           clk = 1'b0;
  logic                           nrst = 1'b0;
  logic                           s_tvalid = 1'b0;
  logic                           s_tready;
  logic [CHANNELS*DATA_WIDTH-1:0] s_tdata = '0;
  logic                           s_tlast = 1'b0;
  logic                           m_tvalid;
  logic                           m_tready = 1'b0;
  frame_t                         m_tdata;
  logic                           m_tlast;
  logic [31:0]                    frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [FRAME_W:0] sb [$];
  frame_t           model_fill = '0;
  int               model_lane = 0;
  bit               bp_mode = 0;
  frame_t           held;

  fir_frame_packer dut (
    .clk       (clk),
    .nrst      (nrst),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tdata   (s_tdata),
    .s_tlast   (s_tlast),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tdata   (m_tdata),
    .m_tlast   (m_tlast),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input frame_t act, input frame_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s = %0h", nm, act);
    end
  endtask

  // Scoreboard monitor: every frame popped by the DUT is compared in order.
  always @(negedge clk) begin
    if (nrst && m_tvalid && m_tready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL frame_pop: unexpected frame tlast=%b data=%h", m_tlast, m_tdata);
      end else begin
        logic [FRAME_W:0] e;
        e = sb.pop_front();
        if ({m_tlast, m_tdata} !== e) begin
          n_bad++;
          $display("FAIL frame_pop: got tlast=%b %h expected tlast=%b %h",
                   m_tlast, m_tdata, e[FRAME_W], e[FRAME_W-1:0]);
        end else begin
          $display("frame tlast=%b data=%h", m_tlast, m_tdata);
        end
      end
    end
  end

  // Drive one sample set at a negedge and return after the accepting edge.
  task automatic send(input int d0, input int d1, input bit last);
    int budget;
    s_tvalid = 1'b1;
    s_tdata  = {DATA_WIDTH'(d1), DATA_WIDTH'(d0)};
    s_tlast  = last;
    budget   = 0;
    while (!s_tready && budget < 200) begin
      if (bp_mode && budget > 2) m_tready = 1'b1;
      @(negedge clk);
      budget++;
    end
    if (!s_tready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: s_tready=%b required 1", s_tready);
      s_tvalid = 1'b0;
      return;
    end
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    model_fill[lane_offset(0, model_lane) +: DATA_WIDTH] = DATA_WIDTH'(d0);
    model_fill[lane_offset(1, model_lane) +: DATA_WIDTH] = DATA_WIDTH'(d1);
    if (model_lane == PSAMPLES - 1 || last) begin
      sb.push_back({last, model_fill});
      model_fill = '0;
      model_lane = 0;
    end else begin
      model_lane++;
    end
  endtask

  task automatic drain(input string nm);
    int budget = 0;
    while (sb.size() != 0 && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    chk(nm, frame_t'(sb.size()), '0);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_s_tready", frame_t'(s_tready), '0);
    chk("rst_m_tvalid", frame_t'(m_tvalid), '0);
    chk("rst_m_tdata", m_tdata, '0);
    chk("rst_frame_cnt", frame_t'(frame_cnt), '0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_s_tready", frame_t'(s_tready), frame_t'(1));

    // Ramp, lossless
    m_tready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      send(n, 1000 + n, 1'b0);
      if (n == 6) chk("ramp_no_early_valid", frame_t'(m_tvalid), '0);
      if (n == 7) begin
        chk("ramp_latency_valid", frame_t'(m_tvalid), frame_t'(1));
        chk("ramp_ch0_lane0", frame_t'(m_tdata[15:0]), frame_t'(0));
        chk("ramp_ch0_lane7", frame_t'(m_tdata[127:112]), frame_t'(7));
        chk("ramp_ch1_lane0", frame_t'(m_tdata[143:128]), frame_t'(1000));
        chk("ramp_ch1_lane7", frame_t'(m_tdata[255:240]), frame_t'(1007));
      end
      if (n == 15) begin
        chk("ramp_frame_cnt", frame_t'(frame_cnt), frame_t'(2));
        chk("ramp_tlast", frame_t'(m_tlast), '0);
      end
    end
    drain("ramp_drained");

    // Partial frame closed by s_tlast
    send(5, 5, 1'b0);
    send(6, 6, 1'b0);
    send(7, 7, 1'b1);
    chk("part_valid", frame_t'(m_tvalid), frame_t'(1));
    chk("part_tlast", frame_t'(m_tlast), frame_t'(1));
    chk("part_ch1_lane2", frame_t'(m_tdata[lane_offset(1, 2) +: DATA_WIDTH]), frame_t'(7));
    chk("part_ch0_lane3_zero", frame_t'(m_tdata[lane_offset(0, 3) +: DATA_WIDTH]), '0);
    chk("part_ch1_lane7_zero", frame_t'(m_tdata[255:240]), '0);
    drain("part_drained");

    // Backpressure: fill the FIFO, hold, then release
    m_tready = 1'b0;
    for (int n = 0; n < 16; n++) send(100 + n, 2000 + n, 1'b0);
    chk("bp_full_s_tready", frame_t'(s_tready), '0);
    chk("bp_full_m_tvalid", frame_t'(m_tvalid), frame_t'(1));
    held = m_tdata;
    repeat (3) @(negedge clk);
    chk("bp_head_stable", m_tdata, held);
    chk("bp_head_lane0", frame_t'(m_tdata[15:0]), frame_t'(100));
    m_tready = 1'b1;
    @(negedge clk);
    chk("bp_s_tready_after_pop", frame_t'(s_tready), frame_t'(1));
    bp_mode = 1;
    for (int n = 16; n < 64; n++) begin
      m_tready = (n % 3 != 0);
      send(100 + n, 2000 + n, 1'b0);
    end
    bp_mode  = 0;
    m_tready = 1'b1;
    drain("bp_drained");
    chk("bp_frame_cnt", frame_t'(frame_cnt), frame_t'(11));

    // Full-scale alternating values
    for (int n = 0; n < 8; n++) begin
      send((n % 2 == 0) ? 32'h7FFF : 32'h8000, (n % 2 == 0) ? 32'h8000 : 32'h7FFF, 1'b0);
    end
    chk("fs_ch0_lane0", frame_t'(m_tdata[lane_offset(0, 0) +: DATA_WIDTH]), frame_t'(16'h7FFF));
    chk("fs_ch0_lane1_sign", frame_t'(m_tdata[lane_offset(0, 1) + DATA_WIDTH - 1]), frame_t'(1));
    chk("fs_ch1_lane0_sign", frame_t'(m_tdata[lane_offset(1, 0) + DATA_WIDTH - 1]), frame_t'(1));
    chk("fs_ch1_lane7", frame_t'(m_tdata[255:240]), frame_t'(16'h7FFF));
    drain("fs_drained");

    // Reset mid-frame with one frame buffered
    m_tready = 1'b0;
    for (int n = 0; n < 13; n++) send(50 + n, 60 + n, 1'b0);
    nrst = 1'b0;
    #1;
    chk("mid_rst_m_tvalid", frame_t'(m_tvalid), '0);
    chk("mid_rst_m_tdata", m_tdata, '0);
    chk("mid_rst_s_tready", frame_t'(s_tready), '0);
    chk("mid_rst_frame_cnt", frame_t'(frame_cnt), '0);
    sb.delete();
    model_fill = '0;
    model_lane = 0;
    @(negedge clk);
    nrst     = 1'b1;
    m_tready = 1'b1;
    repeat (2) @(negedge clk);
    for (int n = 0; n < 8; n++) send(300 + n, 400 + n, 1'b0);
    chk("post_rst_lane0", frame_t'(m_tdata[15:0]), frame_t'(300));
    chk("post_rst_ch1_lane7", frame_t'(m_tdata[255:240]), frame_t'(407));
    chk("post_rst_frame_cnt", frame_t'(frame_cnt), frame_t'(1));
    drain("post_rst_drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
